proc3_pipeline: RTL and testbench
=================================

Name: proc3_pipeline

Overview:
- 16-bit, 3-stage in-order pipelined processor: Fetch (F), Decode/Register-read (D), Execute/Writeback (E).
- 16 x 16-bit register file; separate 8-bit-addressed instruction port and load/store port.
- External memory supplies instructions combinationally; the data port uses a req/ready handshake.
- `powerdown` goes high on HALT so the system can stop.

Parameters:
- DW, 16, datapath and instruction width.
- AW, 8, instruction and data address width.
- NREG, 16, number of registers (4-bit register fields).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr_addr  out  8  PC; the instruction returns combinationally on `instr`.
- instr  in  16  instruction word at `instr_addr`.
- memAddrLoadStore  out  8  load/store address.
- memStoreVal  out  16  store data.
- memLoadVal  in  16  load data, valid when `valueReady`=1.
- valueReady  in  1  load data valid; may stay high between requests.
- readReq  out  1  load request; memory acts on its rising edge.
- writeReq  out  1  store request; memory writes on its rising edge.
- powerdown  out  1  high once HALT executes; sticky.

Behaviour:
- Encoding; op = [15:12]:
  - R-type: rd = [11:8], rs1 = [7:4], rs2 = [3:0].
  - M-type: addr/imm = [11:4], reg = [3:0].
- Opcodes:
  - 0000 NOP.
  - 0001 HALT.
  - 0010 ADD rd = rs1 + rs2.
  - 0011 SUB rd = rs1 − rs2.
  - 0100 MUL rd = low 16 bits of rs1 × rs2 (optional, see below).
  - 0101 AND.
  - 0110 OR.
  - 0111 XOR.
  - 1000 NOT rd = ~rs1.
  - 1001 SLL rd = rs1 << rs2[3:0].
  - 1010 SRL rd = rs1 >> rs2[3:0], logical.
  - 1011 LI reg = zero-extended imm8.
  - 1100 JMP PC = addr8.
  - 1101 reserved, executes as NOP.
  - 1110 LD reg = mem[addr8].
  - 1111 ST mem[addr8] = reg.
- Arithmetic: all results wrap modulo 2^16; no flags.
- Reset (rst=0): PC=0, F/D and D/E pipeline registers hold NOP, all registers 0. Outputs: `readReq`=0, `writeReq`=0, `powerdown`=0, `memAddrLoadStore`=0, `memStoreVal`=0.
- Latency: an instruction fetched at edge n is decoded at n+1, executes and writes back at n+2. Single-cycle ops give 1 instruction per clock.
- Forwarding: the E result is bypassed to D operand reads. A register read in the same cycle as its write returns the new value. No RAW stalls for ALU ops or LI.
- LD, E stage:
  - Cycle 1: drive address, `readReq`=0.
  - Cycle 2: `readReq`=1.
  - Each later cycle with `valueReady`=1: capture `memLoadVal` into reg, drop `readReq`, LD retires.
  - `valueReady` is ignored unless `readReq` was already high on the previous edge.
  - F and D stall throughout.
- ST, E stage:
  - Cycle 1: drive address and data.
  - Cycle 2: `writeReq`=1.
  - Cycle 3: `writeReq`=0, ST retires.
  - Address and data stay stable for all three cycles. F and D stall.
  - Back-to-back stores therefore always give a low→high edge on `writeReq`.
- JMP in E: PC ← addr8; flush F and D to NOP; 2-cycle penalty.
- HALT in E:
  - `powerdown`=1 and stays high until reset.
  - Fetch stops; instructions already in flight are flushed.
- PC: wraps 255→0.
- Reset mid-load or mid-store: abort immediately; `readReq`/`writeReq` drop asynchronously.

Optional Feature:
- Macro: PROC_MUL_EN.
- Defined: opcode 0100 is MUL (combinational 16x16 multiply, low 16 bits kept).
- Undefined: 0100 executes as NOP, no write, and no multiplier is synthesized.

Decomposition:
- Package proc_pkg holds:
  - opcode localparams (OP_NOP … OP_ST);
  - field bit-ranges;
  - DW/AW constants;
  - a typedef for the decoded D/E pipeline record (op, rd, operand values, addr).
- One sub-module, proc_alu: combinational, inputs op/a/b, output 16-bit result; MUL is gated by PROC_MUL_EN.

Test Plan:
- Setup for scenarios 1–4: mem[128]=1, mem[129]=2.
- Scenario 1: program LD R1,[128]=E801; LD R2,[129]=E812; ADD R3,R2,R1=2321; ST R3,[130]=F823 → mem[130]=3.
- Scenario 2: LD R4=1, LD R5=2; SUB R6,R4,R5=3645; ST → mem[130]=0xFFFF (wrap).
- Scenario 3: R7=3, R8=5, with each op followed by ST R9,[130]:
  - AND 5978 → 1.
  - OR → 7.
  - XOR → 6.
  - NOT → 0xFFFC.
  - SLL → 0x0060.
  - SRL → 0.
  - MUL → 15 with PROC_MUL_EN; R9 unchanged without it.
- Scenario 4: forwarding. ADD R3,R1,R1=2311 then ADD R4,R3,R3=2433 back-to-back, ST R4 → mem[130]=4 with no stall cycle.
- Scenario 5: valueReady delayed 3 cycles after `readReq` rises → pipeline stalls, correct value loaded. JMP to 0x20 → the two following instructions are not executed.
- Scenario 6: HALT=1000 → `powerdown` rises 2 cycles after HALT is fetched and stays high. rst low mid-store → `writeReq` drops immediately and PC=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 3-stage processor: widths, opcodes, field ranges, D/E record.
// PROC_MUL_EN enables the MUL opcode (also honoured by proc_alu).
package proc_pkg;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int NREG = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_LI   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RSV  = 4'hD;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_ST   = 4'hF;

  localparam int OP_HI   = 15, OP_LO   = 12;
  localparam int RD_HI   = 11, RD_LO   = 8;
  localparam int RS1_HI  = 7,  RS1_LO  = 4;
  localparam int RS2_HI  = 3,  RS2_LO  = 0;
  localparam int IMM_HI  = 11, IMM_LO  = 4;
  localparam int MREG_HI = 3,  MREG_LO = 0;

  // For ST, b carries the store data; for LI, a carries the zero-extended immediate.
  typedef struct packed {
    logic [3:0]    op;
    logic [3:0]    rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] addr;
  } de_rec_t;

  localparam de_rec_t DE_NOP = '0;

  // Single-cycle ops that write rd from the ALU; LD writes through its own path.
  function automatic logic op_writes_reg(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SLL, OP_SRL, OP_LI: op_writes_reg = 1'b1;
`ifdef PROC_MUL_EN
      OP_MUL:                        op_writes_reg = 1'b1;
`endif
      default:                       op_writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for the execute stage; all results wrap modulo 2^16.
// MUL is only built when PROC_MUL_EN is defined.
module proc_alu
  import proc_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    // NOTE: a default assignment before the case keeps every path driven, so no latch is inferred.
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
`ifdef PROC_MUL_EN
      OP_MUL: y = a * b;
`endif
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SLL: y = a << b[3:0];
      OP_SRL: y = a >> b[3:0];
      OP_LI:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/proc3_pipeline.sv
// 16-bit 3-stage (F/D/E) in-order processor with E->D forwarding and req/ready data port.
// Optional MUL opcode is enabled by defining PROC_MUL_EN.
module proc3_pipeline
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] instr_addr,
  input  logic [DW-1:0] instr,
  output logic [AW-1:0] memAddrLoadStore,
  output logic [DW-1:0] memStoreVal,
  input  logic [DW-1:0] memLoadVal,
  input  logic          valueReady,
  output logic          readReq,
  output logic          writeReq,
  output logic          powerdown
);

  logic [AW-1:0] pc;
  logic [DW-1:0] fd_instr;
  de_rec_t       de;
  de_rec_t       d_rec;
  logic [1:0]    phase;
  logic [DW-1:0] regs [NREG];

  logic [DW-1:0] alu_y;
  logic          ld_done;
  logic          e_stall;
  logic          e_flush;
  logic          wb_en;
  logic [3:0]    wb_rd;
  logic [DW-1:0] wb_data;

  logic [3:0]    d_op;
  logic [3:0]    rs1;
  logic [3:0]    rs2;
  logic [3:0]    mreg;
  logic [AW-1:0] imm;
  logic [DW-1:0] rv1;
  logic [DW-1:0] rv2;
  logic [DW-1:0] rvm;

  assign instr_addr = pc;

  proc_alu u_alu (
    .op (de.op),
    .a  (de.a),
    .b  (de.b),
    .y  (alu_y)
  );

  // Execute stage: LD waits in phase 2 for valueReady; ST retires at the end of phase 2.
  assign ld_done = (de.op == OP_LD) && (phase == 2'd2) && valueReady;
  assign e_stall = ((de.op == OP_LD) && !ld_done) || ((de.op == OP_ST) && (phase != 2'd2));
  assign e_flush = (de.op == OP_JMP) || (de.op == OP_HALT);
  assign wb_en   = ld_done || op_writes_reg(de.op);
  assign wb_rd   = de.rd;
  assign wb_data = (de.op == OP_LD) ? memLoadVal : alu_y;

  // Decode with bypass: a register written this cycle reads back as the new value.
  always_comb begin
    d_op  = fd_instr[OP_HI:OP_LO];
    rs1   = fd_instr[RS1_HI:RS1_LO];
    rs2   = fd_instr[RS2_HI:RS2_LO];
    mreg  = fd_instr[MREG_HI:MREG_LO];
    imm   = fd_instr[IMM_HI:IMM_LO];
    rv1   = (wb_en && wb_rd == rs1)  ? wb_data : regs[rs1];
    rv2   = (wb_en && wb_rd == rs2)  ? wb_data : regs[rs2];
    rvm   = (wb_en && wb_rd == mreg) ? wb_data : regs[mreg];
    d_rec = DE_NOP;
    d_rec.op = d_op;
    if (d_op == OP_LI || d_op == OP_JMP || d_op == OP_LD || d_op == OP_ST) begin
      d_rec.rd   = mreg;
      d_rec.a    = {{(DW-AW){1'b0}}, imm};
      d_rec.b    = rvm;
      d_rec.addr = imm;
    end else begin
      d_rec.rd = fd_instr[RD_HI:RD_LO];
      d_rec.a  = rv1;
      d_rec.b  = rv2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc               <= '0;
      fd_instr         <= '0;
      de               <= DE_NOP;
      phase            <= '0;
      readReq          <= 1'b0;
      writeReq         <= 1'b0;
      powerdown        <= 1'b0;
      memAddrLoadStore <= '0;
      memStoreVal      <= '0;
    end else begin
      if (de.op == OP_LD && phase == 2'd0) readReq <= 1'b1;
      if (ld_done)                         readReq <= 1'b0;
      if (de.op == OP_ST)                  writeReq <= (phase == 2'd0);

      if (e_stall) begin
        if (phase != 2'd2) phase <= phase + 2'd1;
      end else begin
        phase <= '0;
        if (powerdown || e_flush) begin
          fd_instr <= '0;
          de       <= DE_NOP;
          if (de.op == OP_JMP)  pc        <= de.addr;
          if (de.op == OP_HALT) powerdown <= 1'b1;
        end else begin
          de       <= d_rec;
          fd_instr <= instr;
          pc       <= pc + 1'b1;
          // Address and data are latched on entry so they hold for the whole access.
          if (d_rec.op == OP_LD || d_rec.op == OP_ST) memAddrLoadStore <= d_rec.addr;
          if (d_rec.op == OP_ST)                      memStoreVal      <= d_rec.b;
        end
      end
    end
  end

  // NOTE: the register file must read as zero after reset, so it is reset explicitly here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_proc3_pipeline.sv
// Directed bench for proc3_pipeline: instruction/data memory models and a store log.
// Expected values are hand-computed from the instruction semantics.
module tb_proc3_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr_addr;
  logic [15:0] instr;
  logic [7:0]  memAddrLoadStore;
  logic [15:0] memStoreVal;
  logic [15:0] memLoadVal;
  logic        valueReady;
  logic        readReq;
  logic        writeReq;
  logic        powerdown;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          vr_delay = 0;
  int          rr_cnt;
  int          cyc;
  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  st_addr_q [$];
  logic [15:0] st_data_q [$];
  int          st_cyc_q  [$];
  logic        wr_prev = 1'b0;

  always #5 clk = ~clk;

  proc3_pipeline dut (
    .clk              (clk),
    .rst              (rst),
    .instr_addr       (instr_addr),
    .instr            (instr),
    .memAddrLoadStore (memAddrLoadStore),
    .memStoreVal      (memStoreVal),
    .memLoadVal       (memLoadVal),
    .valueReady       (valueReady),
    .readReq          (readReq),
    .writeReq         (writeReq),
    .powerdown        (powerdown)
  );

  assign instr      = imem[instr_addr];
  assign memLoadVal = dmem[memAddrLoadStore];
  assign valueReady = (vr_delay == 0) ? 1'b1 : (readReq && rr_cnt >= vr_delay);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc    <= 0;
      rr_cnt <= 0;
    end else begin
      cyc    <= cyc + 1;
      rr_cnt <= readReq ? rr_cnt + 1 : 0;
    end
  end

  // Each low->high transition of writeReq is one store.
  always @(negedge clk) begin
    if (writeReq && !wr_prev) begin
      st_addr_q.push_back(memAddrLoadStore);
      st_data_q.push_back(memStoreVal);
      st_cyc_q.push_back(cyc);
      dmem[memAddrLoadStore] = memStoreVal;
    end
    wr_prev = writeReq;
  end

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
    dmem[128] = 16'd1;
    dmem[129] = 16'd2;
    st_addr_q.delete();
    st_data_q.delete();
    st_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_prog(input string name, input int max_cyc);
    int n;
    n = 0;
    do_reset();
    while (!powerdown && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (powerdown !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: powerdown=%b after %0d cycles, required 1", name, powerdown, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (instr_addr !== 8'h00)       begin miscompares++; $display("FAIL rst_pc: got %h required 00", instr_addr); end
    if (readReq !== 1'b0)           begin miscompares++; $display("FAIL rst_readReq: got %b required 0", readReq); end
    if (writeReq !== 1'b0)          begin miscompares++; $display("FAIL rst_writeReq: got %b required 0", writeReq); end
    if (powerdown !== 1'b0)         begin miscompares++; $display("FAIL rst_powerdown: got %b required 0", powerdown); end
    if (memAddrLoadStore !== 8'h00) begin miscompares++; $display("FAIL rst_memAddr: got %h required 00", memAddrLoadStore); end
    if (memStoreVal !== 16'h0000)   begin miscompares++; $display("FAIL rst_memStoreVal: got %h required 0000", memStoreVal); end
    rst = 1'b1;
  endtask

  task automatic test_load_add();
    clear_mems();
    imem[0] = 16'hE801; imem[1] = 16'hE812; imem[2] = 16'h2321;
    imem[3] = 16'hF823; imem[4] = 16'h1000;
    run_prog("load_add", 100);
    vectors += 3;
    if (st_data_q.size() != 1) begin
      miscompares++; $display("FAIL load_add_count: got %0d stores required 1", st_data_q.size());
    end
    if (dmem[130] !== 16'd3) begin
      miscompares++; $display("FAIL load_add_value: got %h required 0003", dmem[130]);
    end
    if (readReq !== 1'b0) begin
      miscompares++; $display("FAIL load_add_readReq_idle: got %b required 0", readReq);
    end
  endtask

  task automatic test_sub_wrap();
    clear_mems();
    imem[0] = 16'hE804; imem[1] = 16'hE815; imem[2] = 16'h3645;
    imem[3] = 16'hF826; imem[4] = 16'h1000;
    run_prog("sub_wrap", 100);
    vectors++;
    if (dmem[130] !== 16'hFFFF) begin
      miscompares++; $display("FAIL sub_wrap_value: got %h required ffff", dmem[130]);
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] prog [18];
    logic [15:0] exp_d [7];
    int          n;
    prog = '{16'hB037, 16'hB058, 16'hB5A9, 16'h4978, 16'hF829,
             16'h5978, 16'hF829, 16'h6978, 16'hF829, 16'h7978, 16'hF829,
             16'h8978, 16'hF829, 16'h9978, 16'hF829, 16'hA978, 16'hF829, 16'h1000};
`ifdef PROC_MUL_EN
    exp_d[0] = 16'h000F;
`else
    exp_d[0] = 16'h005A;
`endif
    exp_d[1] = 16'h0001; exp_d[2] = 16'h0007; exp_d[3] = 16'h0006;
    exp_d[4] = 16'hFFFC; exp_d[5] = 16'h0060; exp_d[6] = 16'h0000;
    clear_mems();
    for (int i = 0; i < 18; i++) imem[i] = prog[i];
    run_prog("alu_ops", 300);
    vectors++;
    if (st_data_q.size() != 7) begin
      miscompares++; $display("FAIL alu_count: got %0d stores required 7", st_data_q.size());
    end
    n = (st_data_q.size() < 7) ? st_data_q.size() : 7;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (st_data_q[i] !== exp_d[i] || st_addr_q[i] !== 8'h82) begin
        miscompares++;
        $display("FAIL alu_op%0d: got [%h]=%h required [82]=%h", i, st_addr_q[i], st_data_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mems();
    imem[0] = 16'hE801; imem[1] = 16'h2311; imem[2] = 16'h2433;
    imem[3] = 16'hF824; imem[4] = 16'h1000;
    run_prog("fwd", 100);
    vectors += 2;
    if (st_data_q.size() != 1 || st_data_q[0] !== 16'd4) begin
      miscompares++; $display("FAIL fwd_value: got %0d stores, mem[130]=%h required 0004", st_data_q.size(), dmem[130]);
    end
    // LD edges 2..4, retire 5; ADD 6, ADD 7, ST rises writeReq at edge 8 with no bubble.
    if (st_cyc_q.size() != 1 || st_cyc_q[0] != 8) begin
      miscompares++; $display("FAIL fwd_timing: store at cycle %0d required 8", (st_cyc_q.size() > 0) ? st_cyc_q[0] : -1);
    end
  endtask

  task automatic test_load_wait_jump();
    clear_mems();
    imem[0]     = 16'hE801; imem[1] = 16'hF821; imem[2] = 16'hC200;
    imem[3]     = 16'hB772; imem[4] = 16'hF832; imem[5] = 16'h1000;
    imem[8'h20] = 16'hB333; imem[8'h21] = 16'hF843; imem[8'h22] = 16'h1000;
    vr_delay = 3;
    run_prog("ldwait_jmp", 200);
    vr_delay = 0;
    vectors += 4;
    if (st_data_q.size() != 2) begin
      miscompares++; $display("FAIL jmp_store_count: got %0d stores required 2", st_data_q.size());
    end
    if (st_data_q.size() > 0 && (st_addr_q[0] !== 8'h82 || st_data_q[0] !== 16'd1)) begin
      miscompares++; $display("FAIL ldwait_value: got [%h]=%h required [82]=0001", st_addr_q[0], st_data_q[0]);
    end
    // readReq rises at edge 3, valueReady 3 edges later, load retires at edge 7, store rises at 8.
    if (st_cyc_q.size() > 0 && st_cyc_q[0] != 8) begin
      miscompares++; $display("FAIL ldwait_timing: store at cycle %0d required 8", st_cyc_q[0]);
    end
    if (st_data_q.size() > 1 && (st_addr_q[1] !== 8'h84 || st_data_q[1] !== 16'h0033)) begin
      miscompares++; $display("FAIL jmp_target: got [%h]=%h required [84]=0033", st_addr_q[1], st_data_q[1]);
    end
  endtask

  task automatic test_halt_and_abort();
    clear_mems();
    imem[0] = 16'h1000; imem[1] = 16'hB051; imem[2] = 16'hF821;
    do_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (powerdown !== 1'b0) begin miscompares++; $display("FAIL halt_early: powerdown=%b at cycle 2 required 0", powerdown); end
    @(negedge clk);
    vectors++;
    if (powerdown !== 1'b1) begin miscompares++; $display("FAIL halt_rise: powerdown=%b at cycle 3 required 1", powerdown); end
    repeat (6) @(negedge clk);
    vectors += 2;
    if (powerdown !== 1'b1) begin miscompares++; $display("FAIL halt_sticky: powerdown=%b required 1", powerdown); end
    if (st_data_q.size() != 0) begin miscompares++; $display("FAIL halt_flush: got %0d stores required 0", st_data_q.size()); end

    clear_mems();
    imem[0] = 16'hB051; imem[1] = 16'hF821; imem[2] = 16'h1000;
    do_reset();
    repeat (4) @(negedge clk);
    vectors += 2;
    if (writeReq !== 1'b1)    begin miscompares++; $display("FAIL abort_pre_writeReq: got %b required 1", writeReq); end
    if (instr_addr !== 8'h03) begin miscompares++; $display("FAIL abort_pre_pc: got %h required 03", instr_addr); end
    #2 rst = 1'b0;
    #1;
    vectors += 3;
    if (writeReq !== 1'b0)          begin miscompares++; $display("FAIL abort_writeReq: got %b required 0", writeReq); end
    if (instr_addr !== 8'h00)       begin miscompares++; $display("FAIL abort_pc: got %h required 00", instr_addr); end
    if (memAddrLoadStore !== 8'h00) begin miscompares++; $display("FAIL abort_memAddr: got %h required 00", memAddrLoadStore); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clear_mems();
    test_reset();
    test_load_add();
    test_sub_wrap();
    test_alu_ops();
    test_back_to_back();
    test_load_wait_jump();
    test_halt_and_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
